// File: rtl/sha256_msg_padder.sv
// rtl/sha256_msg_padder.sv - SHA-256 message padder and block issuer; SHA256_PADDER_ABORT_EN adds an abort input
module sha256_msg_padder #(
   parameter int LEN_WIDTH = 64
) (
   input  logic         clk,
   input  logic         rst,
`ifdef SHA256_PADDER_ABORT_EN
   input  logic         abort,
`endif
   input  logic [7:0]   in_data,
   input  logic         in_valid,
   input  logic         in_last,
   output logic         in_ready,
   output logic [511:0] block_out,
   output logic         core_start,
   output logic         first_run,
   input  logic         core_ready,
   output logic         busy,
   output logic         msg_done
);

   typedef enum logic [2:0] {S_FILL, S_ISSUE, S_WAIT, S_REL, S_PADBLK} state_t;
   typedef enum logic [1:0] {PAD_NONE, PAD_P80, PAD_LEN} pad_t;

   state_t               state, state_n;
   pad_t                 pad_pending, pad_n;
   logic [6:0]           idx, idx_n, k;
   logic [LEN_WIDTH-1:0] len, len_n, len_inc;
   logic [63:0]          len_field;
   logic [511:0]         blk_n;
   logic                 final_flag, final_n;
   logic                 first_flag, first_n;
   logic                 busy_n;
   logic                 waited, waited_n;
   logic                 xfer;
   logic                 abort_i;

`ifdef SHA256_PADDER_ABORT_EN
   assign abort_i = abort;
`else
   assign abort_i = 1'b0;
`endif

   assign in_ready  = (state == S_FILL) && !rst;
   assign xfer      = in_valid && in_ready;
   assign k         = idx + 7'd1;
   assign len_inc   = len + LEN_WIDTH'(8);
   // The tail block carries the already-final length; a last data byte still has to count itself.
   assign len_field = (state == S_PADBLK) ? 64'(len) : 64'(len_inc);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_FILL;
         idx         <= '0;
         len         <= '0;
         block_out   <= '0;
         pad_pending <= PAD_NONE;
         final_flag  <= 1'b0;
         first_flag  <= 1'b1;
         busy        <= 1'b0;
         waited      <= 1'b0;
      end else begin
         state       <= state_n;
         idx         <= idx_n;
         len         <= len_n;
         block_out   <= blk_n;
         pad_pending <= pad_n;
         final_flag  <= final_n;
         first_flag  <= first_n;
         busy        <= busy_n;
         waited      <= waited_n;
      end
   end

   always_comb begin
      state_n    = state;
      idx_n      = idx;
      len_n      = len;
      blk_n      = block_out;
      pad_n      = pad_pending;
      final_n    = final_flag;
      first_n    = first_flag;
      busy_n     = busy;
      waited_n   = waited;
      core_start = 1'b0;
      first_run  = 1'b0;
      msg_done   = 1'b0;

      case (state)
         S_FILL: begin
            if (xfer) begin
               idx_n  = k;
               len_n  = len_inc;
               busy_n = 1'b1;
               for (int j = 0; j < 64; j++) begin
                  if (idx == 7'(j))
                     blk_n[511-8*j -: 8] = in_data;
                  else if (in_last && (7'(j) > idx))
                     blk_n[511-8*j -: 8] = (7'(j) == k) ? 8'h80 : 8'h00;
               end
               if (in_last && (k <= 7'd55))
                  blk_n[63:0] = len_field;
               if (in_last) begin
                  state_n = S_ISSUE;
                  if (k <= 7'd55)
                     final_n = 1'b1;
                  else if (k <= 7'd63)
                     pad_n = PAD_LEN;
                  else
                     pad_n = PAD_P80;
               end else if (k == 7'd64) begin
                  state_n = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            core_start = 1'b1;
            first_run  = first_flag;
            first_n    = 1'b0;
            waited_n   = 1'b0;
            state_n    = S_WAIT;
         end
         S_WAIT: begin
            // Ready is still high from the previous block during the first cycle after start.
            waited_n = 1'b1;
            if (waited && core_ready)
               state_n = S_REL;
         end
         S_REL: begin
            if (final_flag) begin
               msg_done = 1'b1;
               len_n    = '0;
               idx_n    = '0;
               first_n  = 1'b1;
               busy_n   = 1'b0;
               final_n  = 1'b0;
               state_n  = S_FILL;
            end else if (pad_pending != PAD_NONE) begin
               state_n = S_PADBLK;
            end else begin
               idx_n   = '0;
               state_n = S_FILL;
            end
         end
         S_PADBLK: begin
            blk_n   = {(pad_pending == PAD_P80) ? 8'h80 : 8'h00, 440'd0, len_field};
            final_n = 1'b1;
            pad_n   = PAD_NONE;
            state_n = S_ISSUE;
         end
         default: state_n = S_FILL;
      endcase

      if (abort_i) begin
         state_n    = S_FILL;
         idx_n      = '0;
         len_n      = '0;
         blk_n      = block_out;
         pad_n      = PAD_NONE;
         final_n    = 1'b0;
         first_n    = 1'b1;
         busy_n     = 1'b0;
         waited_n   = 1'b0;
         core_start = 1'b0;
         first_run  = 1'b0;
         msg_done   = 1'b0;
      end
   end

endmodule
